ffa_fold_scheduler: RTL and testbench

- Sequences the FFA folding datapath.
- For each trial period it:
  - clears that trial's profile row;
  - streams every sample address out of the data buffer;
  - issues one accumulate command per sample, targeting the profile bin that sample falls into.
- Sits between the engine's top-level FSM (start/done) and the data_buffer / profile_memory ports. Phase-bin computation uses a divider-free accumulator.

---
 rtl/ffa_fold_scheduler.sv | 142 ++++++++++++++
 tb/tb_ffa_fold_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ffa_fold_scheduler.sv
// rtl/ffa_fold_scheduler.sv - FFA fold sequencer: clears each trial's profile row, then folds samples into bins.
module ffa_fold_scheduler #(
    parameter int DATA_BUFFER_SIZE  = 16384,
    parameter int PROFILE_BINS      = 256,
    parameter int NUM_TRIAL_PERIODS = 2048,
    parameter int PW                = 16,
    localparam int AW = $clog2(DATA_BUFFER_SIZE),
    localparam int BW = $clog2(PROFILE_BINS),
    localparam int TW = $clog2(NUM_TRIAL_PERIODS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [PW-1:0]   period_min,
    input  logic [TW:0]     num_trials,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic            buf_rd_en,
    output logic [AW-1:0]   buf_rd_addr,
    output logic            prof_we,
    output logic            prof_clr,
    output logic [TW+BW-1:0] prof_addr,
    output logic [PW-1:0]   cur_period
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FOLD,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [PW-1:0] BINS_P   = PW'(PROFILE_BINS);
    localparam logic [PW:0]   BINS_ACC = (PW+1)'(PROFILE_BINS);
    localparam logic [TW:0]   MAX_T    = (TW+1)'(NUM_TRIAL_PERIODS);
    localparam logic [BW-1:0] LAST_BIN = BW'(PROFILE_BINS - 1);
    localparam logic [AW-1:0] LAST_N   = AW'(DATA_BUFFER_SIZE - 1);

    state_t          state;
    logic [PW-1:0]   p;
    logic [TW:0]     t_total;
    logic [TW-1:0]   trial;
    logic [BW-1:0]   clr_idx;
    logic [AW-1:0]   n;
    logic [PW:0]     acc;
    logic [BW-1:0]   bin;
    logic            pend_valid;
    logic [BW-1:0]   pend_bin;

    logic            active;
    logic [PW:0]     acc_sum;
    logic            bin_step;
    logic [TW:0]     trial_next;

    assign active     = (state == S_CLEAR) || (state == S_FOLD) || (state == S_NEXT);
    // p >= PROFILE_BINS keeps acc < p, so a single conditional subtract is an exact phase step.
    assign acc_sum    = acc + BINS_ACC;
    assign bin_step   = acc_sum >= {1'b0, p};
    assign trial_next = {1'b0, trial} + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            p          <= '0;
            t_total    <= '0;
            trial      <= '0;
            clr_idx    <= '0;
            n          <= '0;
            acc        <= '0;
            bin        <= '0;
            pend_valid <= 1'b0;
            pend_bin   <= '0;
        end else if (abort) begin
            state      <= S_IDLE;
            pend_valid <= 1'b0;
        end else if (!(stall && active)) begin
            case (state)
                S_IDLE: begin
                    pend_valid <= 1'b0;
                    if (start) begin
                        p       <= (period_min < BINS_P) ? BINS_P : period_min;
                        t_total <= (num_trials > MAX_T) ? MAX_T : num_trials;
                        trial   <= '0;
                        clr_idx <= '0;
                        state   <= (num_trials == '0) ? S_DONE : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_BIN) begin
                        state <= S_FOLD;
                        n     <= '0;
                        acc   <= '0;
                        bin   <= '0;
                    end
                end
                S_FOLD: begin
                    // The accumulate for sample n is issued next cycle, when its data returns.
                    pend_valid <= 1'b1;
                    pend_bin   <= bin;
                    n          <= n + 1'b1;
                    if (bin_step) begin
                        acc <= acc_sum - {1'b0, p};
                        bin <= bin + 1'b1;
                    end else begin
                        acc <= acc_sum;
                    end
                    if (n == LAST_N) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    pend_valid <= 1'b0;
                    trial      <= trial + 1'b1;
                    p          <= p + 1'b1;
                    clr_idx    <= '0;
                    state      <= (trial_next == t_total) ? S_DONE : S_CLEAR;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = active;
    assign done        = (state == S_DONE);
    assign buf_rd_en   = (state == S_FOLD) && !stall;
    assign buf_rd_addr = (state == S_FOLD) ? n : '0;
    assign prof_we     = ((state == S_CLEAR) || pend_valid) && !stall;
    assign prof_clr    = (state == S_CLEAR) && !stall;
    assign prof_addr   = (state == S_CLEAR) ? {trial, clr_idx} :
                         pend_valid         ? {trial, pend_bin} : '0;
    assign cur_period  = active ? p : '0;

endmodule

// File: tb/tb_ffa_fold_scheduler.sv
// tb/tb_ffa_fold_scheduler.sv - scoreboard bench for ffa_fold_scheduler at small parameters.
module tb_ffa_fold_scheduler;

    localparam int DBS = 16;
    localparam int PB  = 4;
    localparam int NTP = 8;
    localparam int PW  = 16;
    localparam int AW  = 4;
    localparam int BW  = 2;
    localparam int TW  = 3;
    localparam int TRIAL_CYC = PB + DBS + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [PW-1:0]   period_min = '0;
    logic [TW:0]     num_trials = '0;
    logic            stall = 1'b0;
    logic            busy;
    logic            done;
    logic            buf_rd_en;
    logic [AW-1:0]   buf_rd_addr;
    logic            prof_we;
    logic            prof_clr;
    logic [TW+BW-1:0] prof_addr;
    logic [PW-1:0]   cur_period;

    ffa_fold_scheduler #(
        .DATA_BUFFER_SIZE (DBS),
        .PROFILE_BINS     (PB),
        .NUM_TRIAL_PERIODS(NTP),
        .PW               (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .period_min (period_min),
        .num_trials (num_trials),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .buf_rd_en  (buf_rd_en),
        .buf_rd_addr(buf_rd_addr),
        .prof_we    (prof_we),
        .prof_clr   (prof_clr),
        .prof_addr  (prof_addr),
        .cur_period (cur_period)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW+BW-1:0] addr;
        logic             clr;
    } wr_t;

    wr_t          wr_q[$];
    logic [AW-1:0] rd_q[$];
    bit           mon_en = 1'b0;
    bit           stall_en = 1'b0;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected command stream for one trial: PB clears, then per sample a read and an accumulate.
    task automatic push_trial(input int trial, input int p);
        wr_t w;
        for (int b = 0; b < PB; b++) begin
            w.addr = (TW+BW)'(trial * PB + b);
            w.clr  = 1'b1;
            wr_q.push_back(w);
        end
        for (int s = 0; s < DBS; s++) begin
            rd_q.push_back(AW'(s));
            w.addr = (TW+BW)'(trial * PB + ((s * PB) / p) % PB);
            w.clr  = 1'b0;
            wr_q.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall) begin
                check("strobes_while_stalled", {30'd0, buf_rd_en, prof_we}, 32'd0);
            end
            if (buf_rd_en) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 32'd1, 32'd0);
                end else begin
                    check("rd_addr", buf_rd_addr, rd_q.pop_front());
                end
            end
            if (prof_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", prof_addr, e.addr);
                    check("wr_clr", prof_clr, e.clr);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (stall_en) stall = ($urandom_range(0, 2) == 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, buf_rd_en, 0);
        check({tag, "_rd_addr"}, buf_rd_addr, 0);
        check({tag, "_we"}, prof_we, 0);
        check({tag, "_clr"}, prof_clr, 0);
        check({tag, "_addr"}, prof_addr, 0);
        check({tag, "_period"}, cur_period, 0);
    endtask

    task automatic run(input int pmin, input int ntr, input int exp_done, input bit use_stall);
        int t_exp, p0, cyc, busy_cnt;
        t_exp = (ntr > NTP) ? NTP : ntr;
        p0    = (pmin < PB) ? PB : pmin;
        for (int k = 0; k < t_exp; k++) push_trial(k, p0 + k);
        period_min = PW'(pmin);
        num_trials = (TW+1)'(ntr);
        start      = 1'b1;
        stall_en   = use_stall;
        step();
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (!done && cyc < 2000) begin
            if (!use_stall && (cyc - 1) % TRIAL_CYC == 0)
                check("cur_period", cur_period, p0 + (cyc - 1) / TRIAL_CYC);
            if (busy) busy_cnt++;
            step();
            cyc++;
        end
        stall_en = 1'b0;
        stall    = 1'b0;
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
        if (!use_stall) begin
            check("done_latency", cyc, exp_done);
            check("busy_cycles", busy_cnt, exp_done - 1);
        end
        step();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        step();
        check("rd_q_drained", rd_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
    endtask

    initial begin
        wr_t w;
        int cyc;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Async reset in the middle of the fold pass.
        mon_en = 1'b0;
        period_min = 16'd4;
        num_trials = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        check("pre_reset_busy", busy, 1);
        check("pre_reset_rd_en", buf_rd_en, 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midfold_reset");
        step();
        rst = 1'b0;
        step();
        mon_en = 1'b1;

        run(5, 1, 22, 1'b0);
        run(2, 3, 3 * TRIAL_CYC + 1, 1'b0);
        run(0, 0, 1, 1'b0);
        run(4, 9, NTP * TRIAL_CYC + 1, 1'b0);
        run(5, 2, 0, 1'b1);

        // Abort during trial 1 clear, then start coincident with abort while idle.
        push_trial(0, 4);
        for (int b = 0; b < 2; b++) begin
            w.addr = (TW+BW)'(PB + b);
            w.clr  = 1'b1;
            wr_q.push_back(w);
        end
        period_min = 16'd4;
        num_trials = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (cyc < 23) begin
            step();
            cyc++;
        end
        check("abort_pre_busy", busy, 1);
        check("abort_pre_clr", prof_clr, 1);
        abort = 1'b1;
        step();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_we", prof_we, 0);
        check("abort_rd_en", buf_rd_en, 0);
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_ignored", busy, 0);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", done, 0);
            check("abort_stays_idle", busy, 0);
            step();
        end
        check("abort_rd_q", rd_q.size(), 0);
        check("abort_wr_q", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
